// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: shared constants and helpers for the N-to-1 stream mux.
// Holds the mode encoding and a channel-slice extractor for packed buses.
package stream_mux_pkg;

    // Encoding of the mode input.
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Widest packed input bus the slice helper handles (N_CH*WIDTH).
    localparam int BUS_MAX_W = 1024;

    // Returns channel ch of a bus packed as ch*width +: width.
    // The result is right-aligned and the bits above width are cleared.
    // Callers cast the result down to their own data width.
    function automatic logic [BUS_MAX_W-1:0] ch_slice(
        input logic [BUS_MAX_W-1:0] bus,
        input int                   ch,
        input int                   width
    );
        logic [BUS_MAX_W-1:0] mask;
        mask = ~({BUS_MAX_W{1'b1}} << width);
        return (bus >> (ch * width)) & mask;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant over a request vector.
// ptr holds the last granted channel; the search starts at ptr+1 and wraps.
// advance is pulsed by the parent on a transfer and moves ptr to the grant.
module rr_arbiter #(
    parameter  int N_CH  = 4,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  req,
    input  logic             advance,
    output logic [SEL_W-1:0] grant_idx,
    output logic             grant_valid
);

    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] ptr_d;

    // First requester at or after ptr+1, wrapping modulo N_CH.
    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int i = 1; i <= N_CH; i++) begin
            if (!grant_valid && req[(int'(ptr_q) + i) % N_CH]) begin
                grant_valid = 1'b1;
                grant_idx   = SEL_W'((int'(ptr_q) + i) % N_CH);
            end
        end
    end

    // ptr follows the grant only when a beat actually moved.
    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = grant_idx;
        end
    end

    // ptr resets to the last channel so channel 0 has first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= SEL_W'(N_CH - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/stream_mux_nto1.sv
// stream_mux_nto1: N-to-1 streaming multiplexer with one registered output stage.
// Optional round-robin arbitration is compiled in with STREAM_MUX_RR_EN;
// without it the mode port is ignored and only fixed select exists.
//
// Handshake: a beat moves on a rising edge when valid and ready are both high
// on that channel. in_ready is combinational from load_en and the grant, never
// from the same channel's in_valid; out_valid/out_data/out_ch hold steady while
// out_valid is high and out_ready is low.
module stream_mux_nto1
    import stream_mux_pkg::*;
#(
    parameter  int N_CH  = 4,
    parameter  int WIDTH = 4,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH*WIDTH-1:0] in_data,
    output logic [N_CH-1:0]       in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_ch,
    input  logic                  out_ready
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_ch_q,    out_ch_d;

    logic             load_en;
    logic [SEL_W-1:0] grant_idx;
    logic             grant_valid;
    logic             transfer;
    logic [WIDTH-1:0] grant_data;

`ifdef STREAM_MUX_RR_EN
    logic [SEL_W-1:0] arb_idx;
    logic             arb_valid;

    rr_arbiter #(
        .N_CH (N_CH)
    ) u_rr_arbiter (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (in_valid),
        .advance     (transfer && (mode == MODE_RR)),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );
`else
    logic unused_mode;
    assign unused_mode = mode;
`endif

    // The output register can take a beat when empty or draining this cycle.
    assign load_en = !out_valid_q || out_ready;

    // Grant selection: sel in fixed mode (none when out of range), arbiter in RR.
    always_comb begin
        grant_idx   = sel;
        grant_valid = (int'(sel) < N_CH);
`ifdef STREAM_MUX_RR_EN
        if (mode == MODE_RR) begin
            grant_idx   = arb_idx;
            grant_valid = arb_valid;
        end
`endif
    end

    // Ready goes only to the granted channel, gated by load_en.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N_CH; i++) begin
            in_ready[i] = load_en && grant_valid && (int'(grant_idx) == i);
        end
    end

    // A transfer needs a grant, room in the register and the granted valid.
    always_comb begin
        transfer   = grant_valid && load_en && in_valid[grant_idx];
        grant_data = WIDTH'(ch_slice(BUS_MAX_W'(in_data), int'(grant_idx), WIDTH));
    end

    // Next output register contents: load on transfer, clear valid on bare drain.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        if (transfer) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data;
            out_ch_d    = grant_idx;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register stage; reset drops any held beat immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: doc/stream_mux_nto1.md
# stream_mux_nto1

Parametrised N-to-1 streaming multiplexer with a registered output, valid/ready handshakes on every channel and an optional round-robin arbitration mode. It replaces the combinational 4:1 select mux on datapaths where sources are bursty and the sink can stall. It sits between several producer channels and a single consumer. The 4-input, 4-bit case with fixed select reproduces the old mux truth table with one cycle of latency.

## Interface
- N_CH, 4: number of input channels, at least 2.
- WIDTH, 4: data width per channel, at least 1.
- SEL_W, $clog2(N_CH): select and channel-ID width. Derived; never overridden.

- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel select, used in fixed mode.
- in_valid  input  N_CH  per-channel data valid.
- in_data  input  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  N_CH  per-channel accept; combinational.
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  registered data.
- out_ch  output  SEL_W  index of the source channel of the held beat.
- out_ready  input  1  consumer accept.

## Operation
- There is one output register stage: out_valid, out_data and out_ch.
- **Load enable:** `load_en = !out_valid || out_ready`. The register accepts a new beat when it is empty, or when it is being drained in the same cycle.
- **Grant, fixed mode:** grant = sel. If sel >= N_CH, there is no grant and all in_ready are 0.
- **Grant, round-robin mode:** grant goes to the first channel with in_valid set, searching from ptr+1 upward and wrapping modulo N_CH. If no channel is valid, there is no grant.
- **Input ready:** in_ready[g] = load_en for the granted channel g. All other in_ready bits are 0. in_ready never depends on in_valid of the same channel.
- **Transfer:** occurs when in_valid[g] && in_ready[g]. On transfer:
  - out_data <= in_data[g]
  - out_ch <= g
  - out_valid <= 1
  - in round-robin mode only, ptr <= g
- **Drain with no transfer:** if out_valid && out_ready and there is no transfer, out_valid <= 0. out_data and out_ch hold.
- **Stability under back-pressure:** while out_valid && !out_ready, out_data and out_ch are stable regardless of changes to sel, mode or the inputs.
- **Mode or sel change:** takes effect at the next grant decision. A beat already held is never altered.
- ptr updates only on round-robin transfers. Fixed-mode traffic leaves ptr unchanged.

## Timing
- **Reset values** (async assert, released synchronously by the upstream reset synchroniser):
  - out_valid = 0, out_data = 0, out_ch = 0
  - ptr = N_CH-1, so channel 0 has first priority after reset
  - in_ready follows load_en, which is 1 while out_valid = 0. In fixed mode, in_ready[sel] is therefore 1 during and after reset.
- **Latency:** a beat accepted at edge k appears on out_valid/out_data after edge k.
- **Throughput:** 1 beat per cycle when out_ready is held at 1.
- **Reset mid-stream:** out_valid falls immediately, without waiting for clk. The held beat is lost and no partial state survives.
- **Simultaneous drain and load:** the new beat replaces the old one in the same edge, with no bubble.

## Configuration
- **STREAM_MUX_RR_EN defined:** round-robin logic and ptr are compiled in, and the mode port selects the behaviour.
- **STREAM_MUX_RR_EN undefined:** the mode port is present but ignored. The block is fixed-select only, with no ptr register and no arbiter instance.

## Structure
- **Package stream_mux_pkg** holds:
  - the mode encoding constants: MODE_FIXED = 1'b0, MODE_RR = 1'b1
  - a function returning the channel slice of in_data
- **Sub-module rr_arbiter** (N_CH parameter) holds the ptr register.
  - Input: request vector. Outputs: grant index and any-grant.
  - It takes an advance pulse that updates ptr on transfer.

## Test plan
1. **Fixed select:** mode=0, sel=2, all valid, data 1,2,3,4, out_ready=1 → in_ready=4'b0100; the next cycle gives out_data=3, out_ch=2.
2. **Fixed sweep:** sel sequenced 0,1,2,3 one per cycle, out_ready=1 → out_data 1,2,3,4 on consecutive cycles, each one cycle after its sel.
3. **Back-pressure:** beat held with out_ready=0 for 3 cycles while in_data and sel change → out_data and out_ch frozen, in_ready=0. On out_ready=1, the new beat loads in the same edge with no bubble.
4. **Round-robin, all valid:** mode=1, all channels valid, out_ready=1, after reset → out_ch sequence 0,1,2,3,0,1.
5. **Round-robin, sparse:** only ch1 and ch3 valid → out_ch 1,3,1,3. sel ≥ N_CH in fixed mode (N_CH=3, sel=3) → no transfer, out_valid falls after drain.
6. **Async reset mid-stream:** rst_n low between edges with out_valid=1 → out_valid=0 immediately. After release in round-robin mode, the first grant is ch0.
